// File: rtl/inst_fetch_queue_pkg.sv
// inst_fetch_queue shared types and defaults
// Fetch widths, reset vector and queue entry layout
package inst_fetch_queue_pkg;

    localparam int          INST_WIDTH   = 32;
    localparam int          PC_WIDTH     = 32;
    localparam logic [31:0] IFQ_RESET_PC = 32'hBFC0_0000;
    localparam int          IFQ_DEPTH    = 4;

    typedef struct packed {
        logic [PC_WIDTH-1:0]   pc;
        logic [INST_WIDTH-1:0] inst;
    } ifq_entry_t;

    function automatic logic [PC_WIDTH-1:0] word_align(
        input logic [PC_WIDTH-1:0] a
    );
        return {a[PC_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_queue_ifq_fifo.sv
// ifq_fifo: small synchronous FIFO with clear
// Used for the pc-tag list and the instruction queue
module ifq_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;

    // next pointers/count; clear overrides push and pop
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // storage and pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: sequential fetch with prefetch queue and redirect flush
// Option: IFQ_BYPASS_EN presents a response to ID in the same cycle
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = IFQ_DEPTH,
    parameter logic [31:0] RESET_PC = IFQ_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]       outstanding_q, outstanding_d;
    logic [CW-1:0]       drop_q, drop_d;
    logic [CW-1:0]       q_count, tag_count;
    logic [CW:0]         inflight;
    logic                issue, resp_stale, resp_live;
    logic                tag_pop, q_push, q_pop, bypass;
    logic [PC_WIDTH-1:0] tag_pc;
    ifq_entry_t          head, q_wdata;

    assign inflight  = {1'b0, q_count} + {1'b0, outstanding_q};
    assign imem_req  = !rst && !redirect && (inflight < (CW+1)'(DEPTH));
    assign imem_addr = fetch_pc_q;
    assign issue     = imem_req && imem_gnt;

    // stale responses bypass the tag list; live ones consume a tag
    assign resp_stale = imem_rvalid && (drop_q != '0);
    assign tag_pop    = imem_rvalid && (drop_q == '0);
    assign resp_live  = tag_pop && !redirect;

    assign q_wdata.pc   = tag_pc;
    assign q_wdata.inst = imem_rdata;
    assign q_pop        = (q_count != '0) && id_ready && !redirect;
    assign q_push       = resp_live && !bypass;

    // ID-side presentation, optionally short-circuiting an empty queue
    always_comb begin
        bypass   = 1'b0;
        id_valid = (q_count != '0);
        id_pc    = head.pc;
        id_inst  = head.inst;
`ifdef IFQ_BYPASS_EN
        if ((q_count == '0) && resp_live) begin
            bypass   = id_ready;
            id_valid = 1'b1;
            id_pc    = tag_pc;
            id_inst  = imem_rdata;
        end
`endif
    end

    // fetch pointer, in-flight and stale-drop accounting
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        drop_d        = drop_q;
        outstanding_d = outstanding_q + CW'(issue) - CW'(imem_rvalid);
        if (issue) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (resp_stale) begin
            drop_d = drop_q - 1'b1;
        end
        if (redirect) begin
            fetch_pc_d = word_align(redirect_pc);
            drop_d     = outstanding_d;
        end
    end

    // control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    ifq_fifo #(
        .WIDTH (PC_WIDTH),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (redirect),
        .push  (issue),
        .wdata (fetch_pc_q),
        .pop   (tag_pop),
        .rdata (tag_pc),
        .count (tag_count)
    );

    ifq_fifo #(
        .WIDTH ($bits(ifq_entry_t)),
        .DEPTH (DEPTH)
    ) u_inst_q (
        .clk   (clk),
        .rst   (rst),
        .clear (redirect),
        .push  (q_push),
        .wdata (q_wdata),
        .pop   (q_pop),
        .rdata (head),
        .count (q_count)
    );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: scoreboard bench with in-order memory model
// Expected ID stream built from issued requests of the current epoch
module tb_inst_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    always #5 clk = ~clk;

    inst_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RPC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_pc       (id_pc),
        .id_inst     (id_inst)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          epoch;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    req_t        pend[$];
    ent_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          issues = 0;
    int          pops = 0;
    logic [31:0] model_pc = RPC;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // one bus cycle: drive, check request side, advance memory model
    task automatic step(input bit rd, input logic [31:0] tgt,
                        input int gp, input int rp, input int lmax);
        bit   iss;
        bit   rv;
        bit   exp_req;
        req_t r;
        ent_t e;
        @(negedge clk);
        redirect    = rd;
        redirect_pc = tgt;
        imem_gnt    = ($urandom_range(99) < gp);
        id_ready    = ($urandom_range(99) < rp);
        rv          = (pend.size() != 0) && (pend[0].due <= cyc);
        imem_rvalid = rv;
        imem_rdata  = rv ? pend[0].data : $urandom;
        #1;
        exp_req = !rd && ((exp_q.size() + pend.size()) < DEPTH);
        chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        iss = imem_req && imem_gnt;
        if (imem_req) chk("imem_addr", imem_addr, model_pc);
        #2;
        if (rv) begin
            r = pend.pop_front();
            if (!rd && r.epoch == epoch) begin
                e.pc   = r.addr;
                e.inst = r.data;
                exp_q.push_back(e);
            end
        end
        if (iss) begin
            r.addr  = model_pc;
            r.data  = $urandom;
            r.epoch = epoch;
            r.due   = cyc + $urandom_range(lmax, 1);
            pend.push_back(r);
            model_pc = model_pc + 32'd4;
            issues++;
        end
        if (rd) begin
            exp_q.delete();
            epoch++;
            model_pc = {tgt[31:2], 2'b00};
        end
        cyc++;
    endtask

    // monitor: compare ID outputs against scoreboard head
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                chk("id_valid", {31'b0, id_valid},
                    {31'b0, (exp_q.size() != 0)});
                if (exp_q.size() != 0) begin
                    chk("id_pc", id_pc, exp_q[0].pc);
                    chk("id_inst", id_inst, exp_q[0].inst);
                    if (id_ready && !redirect) begin
                        void'(exp_q.pop_front());
                        pops++;
                    end
                end
            end
        end
    end

    initial begin
        int base;
        rst         = 1'b1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        id_ready    = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst imem_req", {31'b0, imem_req}, 32'd0);
        chk("rst imem_addr", imem_addr, RPC);
        chk("rst id_valid", {31'b0, id_valid}, 32'd0);
        chk("rst id_pc", id_pc, 32'd0);
        chk("rst id_inst", id_inst, 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // streaming, latency 1, sustained throughput
        repeat (10) step(0, 0, 100, 100, 1);
        base = pops;
        repeat (20) step(0, 0, 100, 100, 1);
        chk("throughput pops", pops - base, 32'd20);

        // stall: exactly DEPTH requests then hold
        step(1, 32'h0000_1000, 100, 0, 1);
        base = issues;
        repeat (12) step(0, 0, 100, 0, 1);
        chk("stall issues", issues - base, DEPTH);
        repeat (12) step(0, 0, 100, 100, 1);

        // redirect with 3 in flight to unaligned target
        repeat (8) step(0, 0, 100, 100, 3);
        step(1, 32'h0040_0102, 100, 100, 3);
        repeat (12) step(0, 0, 100, 100, 3);

        // redirect while responses land every cycle
        repeat (5) step(0, 0, 100, 100, 1);
        step(1, 32'h0000_2000, 100, 100, 1);
        repeat (5) step(0, 0, 100, 100, 1);

        // back-to-back redirects while stale data still in flight
        repeat (8) step(0, 0, 100, 100, 3);
        step(1, 32'h0000_3000, 100, 100, 3);
        step(0, 0, 100, 100, 3);
        step(1, 32'h8000_0000, 100, 100, 3);
        repeat (12) step(0, 0, 100, 100, 3);

        // address wrap
        step(1, 32'hFFFF_FFF4, 100, 100, 2);
        repeat (15) step(0, 0, 100, 100, 2);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(99) < 3), $urandom,
                 70, 70, 4);
        end
        repeat (20) step(0, 0, 100, 100, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
